// File: rtl/delay_scheduler_if.sv
// Request/grant bundle between delay clients and the shared delay engine.
// The abort lines exist only when DELAY_SCHED_ABORT_EN is defined.
interface delay_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] len;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   tick;
    logic                   busy;
`ifdef DELAY_SCHED_ABORT_EN
    logic [N_REQ-1:0]       abort;

    modport master (output req, len, abort, input grant, done, tick, busy);
    modport slave  (input req, len, abort, output grant, done, tick, busy);
`else
    modport master (output req, len, input grant, done, tick, busy);
    modport slave  (input req, len, output grant, done, tick, busy);
`endif
endinterface

// File: rtl/delay_scheduler.sv
// Shared round-robin delay engine: one prescaler and tick counter serve all clients.
// Optional per-channel cancel is enabled by defining DELAY_SCHED_ABORT_EN.
module delay_scheduler #(
    parameter int N_REQ       = 4,
    parameter int TICK_CYCLES = 12_500_000,
    parameter int LEN_W       = 8
) (
    input logic              CLOCK_50,
    input logic              aclr,
    delay_scheduler_if.slave bus
);
    localparam int PRE_W = $clog2(TICK_CYCLES);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   last_served_q, last_served_d;
    logic [PRE_W-1:0]   prescaler_q, prescaler_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   len_q [N_REQ];
    logic [LEN_W-1:0]   len_d [N_REQ];

    logic [N_REQ-1:0]   accept, cand, abort_idle, abort_run;
    logic               found;
    logic [IDX_W-1:0]   winner;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // An abort on a waiting channel beats a same-cycle req; on the running channel it ends the run.
    always_comb begin
`ifdef DELAY_SCHED_ABORT_EN
        abort_idle = bus.abort & ~grant_q;
        abort_run  = bus.abort & grant_q;
`else
        abort_idle = '0;
        abort_run  = '0;
`endif
        accept = bus.req & ~pending_q & ~abort_idle;
        cand   = pending_q & ~abort_idle;
    end

    always_comb begin
        found  = 1'b0;
        winner = last_served_q;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!found && cand[rr_idx(last_served_q, off)]) begin
                found  = 1'b1;
                winner = rr_idx(last_served_q, off);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = (pending_q | accept) & ~abort_idle;
        len_d         = len_q;
        grant_d       = grant_q;
        done_d        = '0;
        tick_d        = 1'b0;
        last_served_d = last_served_q;
        prescaler_d   = prescaler_q;
        remaining_d   = remaining_q;

        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) len_d[i] = bus.len[i*LEN_W +: LEN_W];
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    pending_d[winner] = 1'b0;
                    last_served_d     = winner;
                    remaining_d       = len_q[winner];
                    prescaler_d       = '0;
                    if (len_q[winner] != '0) begin
                        grant_d = N_REQ'(1) << winner;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort_run != '0) begin
                    grant_d = '0;
                    done_d  = grant_q;
                    state_d = DONE;
                end else if (prescaler_q == PRE_W'(TICK_CYCLES - 1)) begin
                    prescaler_d = '0;
                    tick_d      = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        grant_d = '0;
                        done_d  = grant_q;
                        state_d = DONE;
                    end
                end else begin
                    prescaler_d = prescaler_q + PRE_W'(1);
                end
            end
            DONE: begin
                // Arriving here from IDLE (zero length) the pulse has not been issued yet.
                if (done_q == '0) begin
                    done_d = N_REQ'(1) << last_served_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge aclr) begin
        if (!aclr) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
            last_served_q <= IDX_W'(N_REQ - 1);
            prescaler_q   <= '0;
            remaining_q   <= '0;
            for (int i = 0; i < N_REQ; i++) len_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
            last_served_q <= last_served_d;
            prescaler_q   <= prescaler_d;
            remaining_q   <= remaining_d;
            len_q         <= len_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.tick  = tick_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: directed scenarios plus random traffic against a timestamp model.
// Abort scenarios are included when DELAY_SCHED_ABORT_EN is defined.
module tb_delay_scheduler;
    localparam int N  = 4;
    localparam int T  = 4;
    localparam int LW = 8;

    logic CLOCK_50 = 1'b0;
    logic aclr     = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    delay_scheduler_if #(.N_REQ(N), .LEN_W(LW)) bus();

    delay_scheduler #(.N_REQ(N), .TICK_CYCLES(T), .LEN_W(LW)) dut (
        .CLOCK_50(CLOCK_50),
        .aclr    (aclr),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: each served job is a set of edge timestamps derived from its start edge.
    logic [N-1:0]  m_pend;
    logic [LW-1:0] m_len [N];
    int            m_last;
    int            j_ch, j_start, j_gend, j_done, j_free, j_tlast;
    logic [N-1:0]  e_grant, e_done;
    logic          e_tick, e_busy;

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*LW-1:0] lens(input int a, input int b, input int c, input int d);
        return {LW'(d), LW'(c), LW'(b), LW'(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_pend = '0;
        for (int i = 0; i < N; i++) m_len[i] = '0;
        m_last  = N - 1;
        j_ch    = 0;
        j_start = -1000;
        j_gend  = -1000;
        j_done  = -1000;
        j_free  = -1000;
        j_tlast = -1000;
        e_grant = '0;
        e_done  = '0;
        e_tick  = 1'b0;
        e_busy  = 1'b0;
    endtask

    task automatic modelEdge(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic [N-1:0] a);
        logic [N-1:0] pend_old, abort_ng;
        bit           granted;
        int           w, len_w;
        cyc++;
        granted  = (cyc - 1 >= j_start) && (cyc - 1 < j_gend);
        abort_ng = a;
        if (granted) begin
            abort_ng[j_ch] = 1'b0;
            if (a[j_ch]) begin
                j_gend  = cyc;
                j_done  = cyc;
                j_free  = cyc + 2;
                j_tlast = cyc - 1;
            end
        end
        pend_old = m_pend;
        m_pend   = m_pend & ~abort_ng;
        if (cyc >= j_free) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
            end
            if (w >= 0) begin
                m_pend[w] = 1'b0;
                m_last    = w;
                j_ch      = w;
                j_start   = cyc;
                len_w     = int'(m_len[w]);
                j_gend    = cyc + len_w * T;
                j_tlast   = j_gend;
                j_done    = (len_w == 0) ? cyc + 1 : j_gend;
                j_free    = (len_w == 0) ? cyc + 3 : j_gend + 2;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (r[i] && !pend_old[i] && !abort_ng[i]) begin
                m_pend[i] = 1'b1;
                m_len[i]  = l[i*LW +: LW];
            end
        end
        e_grant = (cyc >= j_start && cyc < j_gend) ? bit_of(j_ch) : '0;
        e_tick  = (cyc > j_start) && (cyc <= j_tlast) && ((cyc - j_start) % T == 0);
        e_done  = (cyc == j_done) ? bit_of(j_ch) : '0;
        e_busy  = (cyc >= j_start) && (cyc < j_free - 1);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic [N-1:0] a);
        bus.req = r;
        bus.len = l;
`ifdef DELAY_SCHED_ABORT_EN
        bus.abort = a;
`endif
        @(posedge CLOCK_50);
        modelEdge(r, l, a);
        @(negedge CLOCK_50);
        checkOutput("grant", 32'(bus.grant), 32'(e_grant));
        checkOutput("done",  32'(bus.done),  32'(e_done));
        checkOutput("tick",  32'(bus.tick),  32'(e_tick));
        checkOutput("busy",  32'(bus.busy),  32'(e_busy));
        bus.req = '0;
`ifdef DELAY_SCHED_ABORT_EN
        bus.abort = '0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0);
    endtask

    // Reset is applied between edges so its effect on the registered outputs is immediate.
    task automatic doReset();
        #2 aclr = 1'b0;
        #1;
        checkOutput("rst_grant", 32'(bus.grant), 32'd0);
        checkOutput("rst_done",  32'(bus.done),  32'd0);
        checkOutput("rst_tick",  32'(bus.tick),  32'd0);
        checkOutput("rst_busy",  32'(bus.busy),  32'd0);
        modelReset();
        repeat (2) @(negedge CLOCK_50);
        aclr = 1'b1;
    endtask

    initial begin
        logic [N-1:0]    r, a;
        logic [N*LW-1:0] l;
        bus.req = '0;
        bus.len = '0;
`ifdef DELAY_SCHED_ABORT_EN
        bus.abort = '0;
`endif
        modelReset();
        @(negedge CLOCK_50);
        doReset();

        $display("[TB] single request, len 3");
        applyStimulus(4'b0001, lens(3, 0, 0, 0), '0);
        idle(16);

        $display("[TB] four simultaneous requests, len 1");
        applyStimulus(4'b1111, lens(1, 1, 1, 1), '0);
        idle(28);

        $display("[TB] zero length on channel 2");
        applyStimulus(4'b0100, lens(0, 0, 0, 0), '0);
        idle(5);

        $display("[TB] repeated req while pending");
        applyStimulus(4'b0001, lens(2, 0, 0, 0), '0);
        applyStimulus(4'b0010, lens(0, 1, 0, 0), '0);
        applyStimulus(4'b0010, lens(0, 3, 0, 0), '0);
        idle(30);

        $display("[TB] reset in the middle of a run");
        applyStimulus(4'b0001, lens(5, 0, 0, 0), '0);
        idle(10);
        doReset();
        idle(4);
        applyStimulus(4'b1001, lens(1, 0, 0, 1), '0);
        idle(16);

`ifdef DELAY_SCHED_ABORT_EN
        $display("[TB] abort of running and pending channels");
        applyStimulus(4'b0011, lens(5, 2, 0, 0), '0);
        idle(2);
        applyStimulus('0, '0, 4'b0011);
        idle(12);
        applyStimulus(4'b0100, lens(0, 0, 2, 0), '0);
        applyStimulus(4'b1000, lens(0, 0, 0, 1), 4'b1000);
        idle(14);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            r = '0;
            a = '0;
            l = '0;
            for (int i = 0; i < N; i++) begin
                r[i]           = ($urandom_range(0, 5) == 0);
                l[i*LW +: LW]  = LW'($urandom_range(0, 3));
`ifdef DELAY_SCHED_ABORT_EN
                a[i]           = ($urandom_range(0, 39) == 0);
`endif
            end
            applyStimulus(r, l, a);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shared programmable-delay engine with round-robin scheduling. Up to N_REQ requesters, for example game-phase FSMs or LED blink sequencers, each post a delay request measured in ticks. The block serves one request at a time on a single prescaler and tick counter, then returns a one-cycle `done` to the requester. It replaces per-FSM fixed delay instances: one counter chain is shared instead of one per client.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TICK_CYCLES, 12_500_000, CLOCK_50 cycles per tick (0.25 s at 50 MHz); ≥2
- LEN_W, 8, width of each requested length in ticks

Ports:
- CLOCK_50  in  1  system clock, single clock domain
- aclr  in  1  asynchronous, active-low reset
- req  in  N_REQ  one-cycle request strobe per channel
- len  in  N_REQ*LEN_W  tick count for channel i at bits [i*LEN_W +: LEN_W]; sampled with req[i]
- grant  out  N_REQ  one-hot; high while channel's delay is running
- done  out  N_REQ  one-cycle completion pulse
- tick  out  1  one-cycle pulse at each completed tick while running
- busy  out  1  high whenever state ≠ IDLE
- abort  in  N_REQ  cancel per channel (present only with DELAY_SCHED_ABORT_EN)

## Operation
- Pending register per channel:
  - req[i]=1 with pending[i]=0 sets pending[i] and latches len[i].
  - req[i] while pending[i]=1 is ignored; the latched length is unchanged.
- States are IDLE, RUN and DONE.
- IDLE:
  - If any pending bit is set, pick the winner round-robin, starting at last_served+1 modulo N_REQ.
  - Clear the winner's pending bit, set last_served to the winner, and load remaining with the winner's latched length.
  - If the length is nonzero, assert grant for the winner and go to RUN. If the length is 0, go to DONE directly; grant is never asserted.
- RUN:
  - The prescaler counts 0..TICK_CYCLES-1 and wraps.
  - At the wrap, pulse tick and decrement remaining.
  - When the decrement reaches 0, drop grant and go to DONE.
- DONE: `done[winner]`=1 for exactly one cycle, then go to IDLE.
- The prescaler restarts at 0 on every new grant, so partial ticks never carry across requests.
- A new req from the channel currently being served is accepted as a fresh pending request. The same applies in its DONE cycle. It is served after the other pending channels.
- Widths:
  - prescaler is clog2(TICK_CYCLES) bits.
  - remaining is LEN_W bits.
  - No overflow is possible: the maximum delay is (2^LEN_W−1)·TICK_CYCLES cycles.

## Timing
- Reset (aclr=0, async):
  - state=IDLE, pending=0, grant=0, done=0, tick=0, busy=0.
  - last_served=N_REQ−1, so channel 0 wins the first arbitration. Prescaler and remaining are 0.
- Reset mid-RUN abandons the request with no done pulse.
- All outputs are registered.
- Latency for a length L>0, with req sampled at edge E0:
  - pending is set after E0.
  - grant is high from E1 to E1+L·TICK_CYCLES.
  - tick pulses at E1+k·TICK_CYCLES, for k=1..L.
  - done is high for one cycle starting at E1+L·TICK_CYCLES; grant is low in that cycle.
  - The next grant can start at E1+L·TICK_CYCLES+2.
- Length 0: done is high for the cycle starting at E2, with no grant and no tick.
- Simultaneous requests on an idle engine are granted in round-robin order, one request per grant cycle.

## Configuration
- With `DELAY_SCHED_ABORT_EN` defined:
  - The abort port exists.
  - abort[i] on a pending, non-granted channel clears pending[i] with no done pulse.
  - abort[i] on the granted channel moves the state to DONE at the next edge. done[i] pulses and tick is suppressed.
  - If abort[i] and req[i] occur in the same cycle on a non-granted channel, abort wins.
- Without the macro: the port is absent and the abort logic is not generated.

## Test plan
- TICK_CYCLES=4, req[0] with len 3 at E0: grant[0] high from E1 for 12 cycles, tick at E5, E9 and E13, done[0] in the cycle starting E13, busy back low at E14.
- req[0..3] together, each len 1: grants follow order 0,1,2,3, each lasting 4 cycles, with a 2-cycle gap between grants.
- len 0 on channel 2: done[2] at E2; grant and tick stay 0.
- aclr low at the midpoint of RUN: all outputs go 0 immediately; no done pulse after release; channel 0 wins the next arbitration.
- req[1] repeated while pending with a different len: the original length is used.
- Abort, with the macro enabled: abort[0] two cycles into a len-5 run gives done[0] on the next cycle and no further ticks. Abort of a pending channel 1 means channel 1 is never granted.
